// File: rtl/div7_pkg.sv
// -----------------------------------------------------------------------------
// div7_pkg
// Shared definitions for the 7-bit signed sequential divider: operand width,
// FSM state encoding, fixed result codes and two's-complement helpers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package div7_pkg;

    localparam int W     = 7;
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Quotient reported on a zero divisor (-1).
    localparam logic [W-1:0] DIV0_Q  = 7'h7F;
    // Most negative operand; its magnitude 64 still fits in W unsigned bits.
    localparam logic [W-1:0] MIN_NEG = 7'h40;

    // Two's-complement negation modulo 2^W.
    function automatic logic [W-1:0] neg(input logic [W-1:0] x);
        return ~x + {{(W-1){1'b0}}, 1'b1};
    endfunction

    // Unsigned magnitude of a signed operand.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? neg(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_i   partial remainder (W+1 bits, always < divisor magnitude)
//   bit_i   next dividend bit shifted into the remainder
//   dmag_i  divisor magnitude
//   rem_o   next partial remainder
//   q_o     quotient bit produced by this step
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module div_step
    import div7_pkg::*;
(
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dmag_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem_i[W-1:0], bit_i};

    // Subtract as add of the inverted operand with carry-in 1. Since the
    // shifted remainder is below 2*|divisor|, the difference lies in
    // [-64, 63] and its MSB is exactly the borrow.
    assign diff  = shifted + ~{1'b0, dmag_i} + {{W{1'b0}}, 1'b1};
    assign q_o   = ~diff[W];
    assign rem_o = q_o ? diff : shifted;

endmodule

// File: rtl/divider_7b.sv
// -----------------------------------------------------------------------------
// divider_7b
// Sequential signed divider for W-bit two's-complement operands. Restoring
// shift-and-subtract on magnitudes, one quotient bit per clock, followed by a
// sign fix-up cycle. Quotient truncates toward zero; remainder takes the sign
// of the dividend.
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   dividend, divisor     signed operands
//   out_valid / out_ready result handshake
//   quotient, remainder   signed results
//   div_by_zero           divisor was zero (quotient -1, remainder = dividend)
//   overflow              -64 / -1, quotient wraps to 7'h40
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module divider_7b
    import div7_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W:0]       prem_q;      // partial remainder
    logic [W-1:0]     qsr_q;       // dividend bits out, quotient bits in
    logic [W-1:0]     dmag_q;
    logic             sd_q;
    logic             sv_q;
    logic             ovf_pend_q;

    logic             out_valid_q;
    logic [W-1:0]     quotient_q;
    logic [W-1:0]     remainder_q;
    logic             dbz_q;
    logic             ovf_q;

    logic [W:0]       prem_d;
    logic             qbit_d;

    div_step u_step (
        .rem_i  (prem_q),
        .bit_i  (qsr_q[W-1]),
        .dmag_i (dmag_q),
        .rem_o  (prem_d),
        .q_o    (qbit_d)
    );

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    // NOTE: every register here is assigned with <= so all of them sample the
    // pre-edge values; a blocking = would let later statements see new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            qsr_q       <= '0;
            dmag_q      <= '0;
            sd_q        <= 1'b0;
            sv_q        <= 1'b0;
            ovf_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sd_q       <= dividend[W-1];
                        sv_q       <= divisor[W-1];
                        dmag_q     <= mag(divisor);
                        ovf_pend_q <= (dividend == MIN_NEG) && (divisor == {W{1'b1}});
                        if (divisor == '0) begin
                            // Zero divisor skips the iteration entirely.
                            quotient_q  <= DIV0_Q;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            cnt_q   <= CNT_W'(W - 1);
                            prem_q  <= '0;
                            qsr_q   <= mag(dividend);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    qsr_q  <= {qsr_q[W-2:0], qbit_d};
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    // -64 / -1 yields magnitude 64, which reads back as 7'h40.
                    quotient_q  <= (sd_q ^ sv_q) ? neg(qsr_q) : qsr_q;
                    remainder_q <= sd_q ? neg(prem_q[W-1:0]) : prem_q[W-1:0];
                    ovf_q       <= ovf_pend_q;
                    dbz_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_7b.sv
`timescale 1ns/1ps
module tb_divider_7b;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divider_7b dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Directed cases: operands and hand-derived expected results.
    localparam int ND = 9;
    localparam logic [W-1:0] DIR_A [ND] = '{7'h2D, 7'h53, 7'h2D, 7'h53, 7'h40, 7'h40, 7'h05, 7'h0C, 7'h7B};
    localparam logic [W-1:0] DIR_B [ND] = '{7'h07, 7'h07, 7'h79, 7'h79, 7'h7F, 7'h01, 7'h40, 7'h00, 7'h00};
    localparam logic [W-1:0] DIR_Q [ND] = '{7'h06, 7'h7A, 7'h7A, 7'h06, 7'h40, 7'h40, 7'h00, 7'h7F, 7'h7F};
    localparam logic [W-1:0] DIR_R [ND] = '{7'h03, 7'h7D, 7'h03, 7'h7D, 7'h00, 7'h00, 7'h05, 7'h0C, 7'h7B};
    localparam logic         DIR_Z [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic         DIR_O [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reference: plain integer division (truncating, remainder follows dividend).
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz, output logic ovf);
        int ia, ib, iq, ir;
        ia  = int'($signed(a));
        ib  = int'($signed(b));
        dbz = 1'b0;
        ovf = 1'b0;
        if (ib == 0) begin
            q   = 7'h7F;
            r   = a;
            dbz = 1'b1;
        end else begin
            iq  = ia / ib;
            ir  = ia % ib;
            q   = iq[W-1:0];
            r   = ir[W-1:0];
            ovf = (iq > 63);
        end
    endfunction

    // Issue one operation at a falling edge, wait (bounded) for the result while
    // wiggling inputs that must be ignored, then consume it on the next rising edge.
    // lat counts rising edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dbz, output logic ovf, output int lat,
                          output logic rdy_issue, output logic busy_ok);
        @(negedge clk);
        out_ready = 1'b0;
        rdy_issue = in_ready;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat     = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 30) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom);
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(negedge clk);
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        in_valid  = 1'b0;
        q         = quotient;
        r         = remainder;
        dbz       = div_by_zero;
        ovf       = overflow;
        out_ready = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !==
            {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b ov=%b q=%h r=%h z=%b o=%b, want rdy=1 ov=0 q=00 r=00 z=0 o=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] q, r;
        logic dbz, ovf, rdy, busy_ok;
        int lat, elat;
        for (int i = 0; i < ND; i++) begin
            run_op(DIR_A[i], DIR_B[i], q, r, dbz, ovf, lat, rdy, busy_ok);
            elat = DIR_Z[i] ? 0 : 8;
            checks++;
            if ({q, r, dbz, ovf} !== {DIR_Q[i], DIR_R[i], DIR_Z[i], DIR_O[i]}) begin
                failures++;
                $display("FAIL directed_%0d result (%h/%h): got q=%h r=%h z=%b o=%b, want q=%h r=%h z=%b o=%b",
                         i, DIR_A[i], DIR_B[i], q, r, dbz, ovf, DIR_Q[i], DIR_R[i], DIR_Z[i], DIR_O[i]);
            end
            checks++;
            if (lat !== elat) begin
                failures++;
                $display("FAIL directed_%0d latency: got %0d, want %0d", i, lat, elat);
            end
            checks++;
            if ({rdy, busy_ok} !== 2'b11) begin
                failures++;
                $display("FAIL directed_%0d in_ready: got ready_at_issue=%b low_while_busy=%b, want 1 1",
                         i, rdy, busy_ok);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic dbz, ovf, edbz, eovf, rdy, busy_ok;
        int lat, elat;
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(a, b, eq, er, edbz, eovf);
            elat = edbz ? 0 : 8;
            run_op(a, b, q, r, dbz, ovf, lat, rdy, busy_ok);
            checks++;
            if ({q, r, dbz, ovf, lat, rdy, busy_ok} !== {eq, er, edbz, eovf, elat, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL random_%0d (%h/%h): got q=%h r=%h z=%b o=%b lat=%0d rdy=%b busy=%b, want q=%h r=%h z=%b o=%b lat=%0d rdy=1 busy=1",
                         i, a, b, q, r, dbz, ovf, lat, rdy, busy_ok, eq, er, edbz, eovf, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] q, r;
        logic dbz, ovf, rdy, busy_ok, stable_ok;
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        dividend  = 7'h2D;
        divisor   = 7'h07;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !==
                {1'b1, 1'b0, 7'h06, 7'h03, 1'b0, 1'b0}) stable_ok = 1'b0;
        end
        checks++;
        if (stable_ok !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_hold: got stable=%b (ov=%b rdy=%b q=%h r=%h), want stable=1 with q=06 r=03",
                     stable_ok, out_valid, in_ready, quotient, remainder);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL backpressure_release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        run_op(7'h14, 7'h03, q, r, dbz, ovf, lat, rdy, busy_ok);
        checks++;
        if ({q, r, dbz, ovf, lat, rdy} !== {7'h06, 7'h02, 1'b0, 1'b0, 8, 1'b1}) begin
            failures++;
            $display("FAIL backpressure_next: got q=%h r=%h z=%b o=%b lat=%0d rdy=%b, want q=06 r=02 z=0 o=0 lat=8 rdy=1",
                     q, r, dbz, ovf, lat, rdy);
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] q, r;
        logic dbz, ovf, rdy, busy_ok, emitted;
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        dividend  = 7'h53;
        divisor   = 7'h07;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !==
            {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_state: got rdy=%b ov=%b q=%h r=%h z=%b o=%b, want rdy=1 ov=0 q=00 r=00 z=0 o=0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        rst = 1'b0;
        emitted = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) emitted = 1'b1;
        end
        checks++;
        if (emitted !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_discard: got out_valid seen=%b, want 0", emitted);
        end
        run_op(7'h14, 7'h03, q, r, dbz, ovf, lat, rdy, busy_ok);
        checks++;
        if ({q, r, dbz, ovf, lat, rdy} !== {7'h06, 7'h02, 1'b0, 1'b0, 8, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset_after: got q=%h r=%h z=%b o=%b lat=%0d rdy=%b, want q=06 r=02 z=0 o=0 lat=8 rdy=1",
                     q, r, dbz, ovf, lat, rdy);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
